// File: rtl/tlbmiss_arbiter.sv
// tlbmiss_arbiter: shares one page-table walker between the ITLB and the DTLB.
//
// Ports
//   clk, reset             clock and synchronous active-low reset
//   ITLBMissF, DTLBMissM   level miss requests from fetch and memory stages
//   IVAdr, DVAdr           virtual addresses for the two misses
//   DWriteAccess           DTLB miss is a store/AMO
//   TLBFlush               sfence.vma / satp write: cancel or drain the walk
//   WalkReq/WalkAck        request handshake to the walker
//   WalkVAdr, WalkIsInstr, WalkIsWrite   latched request attributes
//   WalkDone, WalkFault, WalkPTE, WalkPageType   walk result, valid on WalkDone
//   WalkAbort              one-cycle abandon pulse to the walker
//   PTE, PageTypeWriteVal  registered result for the TLB write
//   ITLBWrite, DTLBWrite   one-cycle TLB write strobes
//   IWalkFault, DWalkFault one-cycle page-fault pulses
//   Busy                   FSM is not idle
module tlbmiss_arbiter #(
  parameter int unsigned XLEN       = 64,
  parameter int unsigned FAIR_LIMIT = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ITLBMissF,
  input  logic            DTLBMissM,
  input  logic [XLEN-1:0] IVAdr,
  input  logic [XLEN-1:0] DVAdr,
  input  logic            DWriteAccess,
  input  logic            TLBFlush,
  output logic            WalkReq,
  input  logic            WalkAck,
  output logic [XLEN-1:0] WalkVAdr,
  output logic            WalkIsInstr,
  output logic            WalkIsWrite,
  input  logic            WalkDone,
  input  logic            WalkFault,
  input  logic [XLEN-1:0] WalkPTE,
  input  logic [1:0]      WalkPageType,
  output logic            WalkAbort,
  output logic [XLEN-1:0] PTE,
  output logic [1:0]      PageTypeWriteVal,
  output logic            ITLBWrite,
  output logic            DTLBWrite,
  output logic            IWalkFault,
  output logic            DWalkFault,
  output logic            Busy
);

  localparam logic [3:0] FairLimit = 4'(FAIR_LIMIT);

  typedef enum logic [2:0] {StIdle, StReq, StWalk, StResp, StDrain} state_e;

  state_e          state_q, state_d;
  logic [3:0]      fair_cnt_q, fair_cnt_d;
  logic            owner_instr_q, owner_instr_d;
  logic [XLEN-1:0] vadr_q, vadr_d;
  logic            write_q, write_d;
  logic [XLEN-1:0] pte_q, pte_d;
  logic [1:0]      ptype_q, ptype_d;
  logic            fault_q, fault_d;

  logic grant;
  logic grant_instr;
  logic owner_miss;
  logic result_take;

  // Grant decode: DTLB wins unless it is absent or the ITLB has been starved
  // for FairLimit consecutive DTLB grants.
  assign grant       = (state_q == StIdle) & ~TLBFlush & (ITLBMissF | DTLBMissM);
  assign grant_instr = ITLBMissF & (~DTLBMissM | (fair_cnt_q == FairLimit));
  assign owner_miss  = owner_instr_q ? ITLBMissF : DTLBMissM;
  assign result_take = (state_q == StWalk) & WalkDone & ~TLBFlush;

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (grant) state_d = StReq;
      end
      StReq: begin
        // A same-cycle ack commits the walker, so it beats a withdrawn miss.
        if (WalkAck) begin
          state_d = TLBFlush ? StDrain : StWalk;
        end else if (!owner_miss || TLBFlush) begin
          state_d = StIdle;
        end
      end
      StWalk: begin
        if (WalkDone) begin
          state_d = TLBFlush ? StIdle : StResp;
        end else if (TLBFlush) begin
          state_d = StDrain;
        end
      end
      StResp:  state_d = StIdle;
      StDrain: begin
        if (WalkDone) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    WalkReq     = 1'b0;
    WalkVAdr    = '0;
    WalkIsInstr = 1'b0;
    WalkIsWrite = 1'b0;
    WalkAbort   = 1'b0;
    ITLBWrite   = 1'b0;
    DTLBWrite   = 1'b0;
    IWalkFault  = 1'b0;
    DWalkFault  = 1'b0;
    case (state_q)
      StReq: begin
        WalkReq     = 1'b1;
        WalkVAdr    = vadr_q;
        WalkIsInstr = owner_instr_q;
        WalkIsWrite = write_q;
        WalkAbort   = WalkAck & TLBFlush;
      end
      StWalk: begin
        WalkAbort = TLBFlush & ~WalkDone;
      end
      StResp: begin
        ITLBWrite  = owner_instr_q  & ~fault_q & ~TLBFlush;
        DTLBWrite  = ~owner_instr_q & ~fault_q & ~TLBFlush;
        IWalkFault = owner_instr_q  &  fault_q & ~TLBFlush;
        DWalkFault = ~owner_instr_q &  fault_q & ~TLBFlush;
      end
      default: ;
    endcase
  end

  assign Busy             = (state_q != StIdle);
  assign PTE              = pte_q;
  assign PageTypeWriteVal = ptype_q;

  // Request latches, fairness counter and result registers
  always_comb begin
    fair_cnt_d    = fair_cnt_q;
    owner_instr_d = owner_instr_q;
    vadr_d        = vadr_q;
    write_d       = write_q;
    pte_d         = pte_q;
    ptype_d       = ptype_q;
    fault_d       = fault_q;
    if (grant) begin
      owner_instr_d = grant_instr;
      vadr_d        = grant_instr ? IVAdr : DVAdr;
      write_d       = ~grant_instr & DWriteAccess;
      // Count only DTLB grants that made a waiting ITLB miss lose.
      if (!grant_instr && ITLBMissF) begin
        fair_cnt_d = (fair_cnt_q >= FairLimit) ? FairLimit : fair_cnt_q + 4'd1;
      end else begin
        fair_cnt_d = '0;
      end
    end
    if (result_take) begin
      pte_d   = WalkPTE;
      ptype_d = WalkPageType;
      fault_d = WalkFault;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      fair_cnt_q    <= '0;
      owner_instr_q <= 1'b0;
      vadr_q        <= '0;
      write_q       <= 1'b0;
      pte_q         <= '0;
      ptype_q       <= '0;
      fault_q       <= 1'b0;
    end else begin
      fair_cnt_q    <= fair_cnt_d;
      owner_instr_q <= owner_instr_d;
      vadr_q        <= vadr_d;
      write_q       <= write_d;
      pte_q         <= pte_d;
      ptype_q       <= ptype_d;
      fault_q       <= fault_d;
    end
  end

endmodule

// File: tb/tb_tlbmiss_arbiter.sv
// tb_tlbmiss_arbiter: directed plus randomized transactions against a
// transaction-level model of arbitration, fairness and result delivery.
module tb_tlbmiss_arbiter;
  localparam int unsigned XLEN  = 64;
  localparam int unsigned LIMIT = 3;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            ITLBMissF = 1'b0, DTLBMissM = 1'b0;
  logic [XLEN-1:0] IVAdr = '0, DVAdr = '0;
  logic            DWriteAccess = 1'b0, TLBFlush = 1'b0;
  logic            WalkReq, WalkAck = 1'b0;
  logic [XLEN-1:0] WalkVAdr;
  logic            WalkIsInstr, WalkIsWrite;
  logic            WalkDone = 1'b0, WalkFault = 1'b0;
  logic [XLEN-1:0] WalkPTE = '0;
  logic [1:0]      WalkPageType = '0;
  logic            WalkAbort;
  logic [XLEN-1:0] PTE;
  logic [1:0]      PageTypeWriteVal;
  logic            ITLBWrite, DTLBWrite, IWalkFault, DWalkFault, Busy;

  tlbmiss_arbiter #(.XLEN(XLEN), .FAIR_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset), .ITLBMissF(ITLBMissF), .DTLBMissM(DTLBMissM),
    .IVAdr(IVAdr), .DVAdr(DVAdr), .DWriteAccess(DWriteAccess), .TLBFlush(TLBFlush),
    .WalkReq(WalkReq), .WalkAck(WalkAck), .WalkVAdr(WalkVAdr), .WalkIsInstr(WalkIsInstr),
    .WalkIsWrite(WalkIsWrite), .WalkDone(WalkDone), .WalkFault(WalkFault),
    .WalkPTE(WalkPTE), .WalkPageType(WalkPageType), .WalkAbort(WalkAbort), .PTE(PTE),
    .PageTypeWriteVal(PageTypeWriteVal), .ITLBWrite(ITLBWrite), .DTLBWrite(DTLBWrite),
    .IWalkFault(IWalkFault), .DWalkFault(DWalkFault), .Busy(Busy)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  int          fcnt = 0;     // model of consecutive DTLB wins over a waiting ITLB
  logic        exp_i;
  logic [63:0] exp_va;
  logic        exp_w;
  logic        obs_i;
  bit          allow_drop = 1'b1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] strobes();
    return {ITLBWrite, DTLBWrite, IWalkFault, DWalkFault};
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req"}, WalkReq, 0);
    chk({tag, "_va"}, WalkVAdr, 0);
    chk({tag, "_isi"}, WalkIsInstr, 0);
    chk({tag, "_isw"}, WalkIsWrite, 0);
    chk({tag, "_abort"}, WalkAbort, 0);
    chk({tag, "_pte"}, PTE, 0);
    chk({tag, "_pt"}, PageTypeWriteVal, 0);
    chk({tag, "_strobes"}, strobes(), 0);
    chk({tag, "_busy"}, Busy, 0);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, Busy, 0);
    chk({tag, "_req"}, WalkReq, 0);
    chk({tag, "_abort"}, WalkAbort, 0);
    chk({tag, "_strobes"}, strobes(), 0);
  endtask

  // Called in an IDLE cycle; returns in the first REQ cycle.
  task automatic t_grant(input logic im, input logic dm, input logic [63:0] iva,
                         input logic [63:0] dva, input logic dw);
    ITLBMissF = im; DTLBMissM = dm; IVAdr = iva; DVAdr = dva; DWriteAccess = dw;
    TLBFlush = 0; WalkAck = 0; WalkDone = 0; WalkFault = 0;
    #1;
    chk_idle("idle");
    exp_i  = im && (!dm || fcnt == LIMIT);
    exp_va = exp_i ? iva : dva;
    exp_w  = !exp_i && dw;
    if (exp_i || !im) fcnt = 0;
    else fcnt = (fcnt >= LIMIT) ? LIMIT : fcnt + 1;
    tick();
    obs_i = WalkIsInstr;
    chk("req_walkreq", WalkReq, 1);
    chk("req_isinstr", WalkIsInstr, exp_i);
    chk("req_vadr", WalkVAdr, exp_va);
    chk("req_iswrite", WalkIsWrite, exp_w);
    chk("req_busy", Busy, 1);
  endtask

  // Hold REQ without ack while the source addresses change underneath.
  task automatic req_hold(input int n);
    repeat (n) begin
      IVAdr = rnd64(); DVAdr = rnd64(); DWriteAccess = 1'($urandom);
      #1;
      chk("hold_walkreq", WalkReq, 1);
      chk("hold_vadr", WalkVAdr, exp_va);
      chk("hold_iswrite", WalkIsWrite, exp_w);
      tick();
    end
  endtask

  task automatic drain(input int n);
    repeat (n) begin
      #1;
      chk("drain_busy", Busy, 1);
      chk("drain_abort", WalkAbort, 0);
      chk("drain_strobes", strobes(), 0);
      tick();
    end
    WalkDone = 1; WalkPTE = rnd64(); WalkFault = 1'($urandom);
    #1;
    chk("drain_done_strobes", strobes(), 0);
    chk("drain_done_abort", WalkAbort, 0);
    tick();
    WalkDone = 0;
    #1;
    chk_idle("drain_exit");
  endtask

  // scen: 0 ok, 1 fault, 2 flush in WALK, 3 flush in RESP, 4 withdraw in REQ,
  //       5 flush in REQ, 6 flush with ack, 7 flush with done
  task automatic txn(input int scen, input logic im, input logic dm, input logic [63:0] iva,
                     input logic [63:0] dva, input logic dw, input int nack, input int nwalk,
                     input logic [63:0] pte, input logic [1:0] pt, input logic flt_in);
    logic [3:0] exp_s;
    logic       flt;
    flt = (scen == 1) ? 1'b1 : flt_in;
    t_grant(im, dm, iva, dva, dw);
    req_hold(nack);
    if (scen == 4) begin
      if (exp_i) ITLBMissF = 0; else DTLBMissM = 0;
      #1;
      chk("wd_abort", WalkAbort, 0);
      tick();
      #1;
      chk_idle("wd_exit");
    end else if (scen == 5) begin
      TLBFlush = 1;
      #1;
      chk("fr_abort", WalkAbort, 0);
      tick();
      #1;
      chk_idle("fr_exit");
    end else if (scen == 6) begin
      TLBFlush = 1; WalkAck = 1;
      #1;
      chk("fa_abort", WalkAbort, 1);
      tick();
      TLBFlush = 0; WalkAck = 0;
      #1;
      chk("fa_abort_once", WalkAbort, 0);
      chk("fa_walkreq", WalkReq, 0);
      chk("fa_busy", Busy, 1);
      drain(nwalk);
    end else begin
      WalkAck = 1;
      #1;
      chk("ack_abort", WalkAbort, 0);
      tick();
      WalkAck = 0;
      #1;
      chk("walk_walkreq", WalkReq, 0);
      chk("walk_busy", Busy, 1);
      repeat (nwalk) begin
        // A withdrawn miss must not cancel the walk.
        if (allow_drop && $urandom_range(0, 1) == 1) begin ITLBMissF = 0; DTLBMissM = 0; end
        #1;
        chk("walk_hold_busy", Busy, 1);
        chk("walk_hold_abort", WalkAbort, 0);
        tick();
      end
      if (scen == 2) begin
        TLBFlush = 1;
        #1;
        chk("fw_abort", WalkAbort, 1);
        tick();
        TLBFlush = 0;
        #1;
        chk("fw_abort_once", WalkAbort, 0);
        chk("fw_busy", Busy, 1);
        drain(nwalk);
      end else if (scen == 7) begin
        TLBFlush = 1; WalkDone = 1; WalkPTE = pte; WalkPageType = pt; WalkFault = flt;
        #1;
        chk("fd_abort", WalkAbort, 0);
        tick();
        TLBFlush = 0; WalkDone = 0;
        #1;
        chk_idle("fd_exit");
      end else begin
        WalkDone = 1; WalkPTE = pte; WalkPageType = pt; WalkFault = flt;
        #1;
        chk("done_abort", WalkAbort, 0);
        chk("done_strobes", strobes(), 0);
        tick();
        WalkDone = 0; WalkPTE = rnd64(); WalkPageType = 2'($urandom); WalkFault = 1'($urandom);
        TLBFlush = (scen == 3);
        if (scen == 3) exp_s = 4'b0000;
        else if (exp_i) exp_s = flt ? 4'b0010 : 4'b1000;
        else exp_s = flt ? 4'b0001 : 4'b0100;
        #1;
        chk("resp_strobes", strobes(), exp_s);
        chk("resp_pte", PTE, pte);
        chk("resp_pt", PageTypeWriteVal, pt);
        chk("resp_busy", Busy, 1);
        tick();
        TLBFlush = 0;
        #1;
        chk_idle("resp_exit");
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] seq;
    int         scen;
    logic       im, dm;

    reset = 0;
    repeat (2) tick();
    reset = 1;
    #1;
    chk_all_zero("reset");

    // ITLB-only miss, clean walk
    txn(0, 1, 0, 64'h8000_1000, 64'h0, 0, 1, 1, 64'h2000_04CF, 2'd0, 0);
    // DTLB store miss that faults
    txn(1, 0, 1, 64'h0, 64'h4000_2008, 1, 0, 2, 64'h0, 2'd1, 1);
    txn(2, 1, 0, 64'h8000_3000, 64'h0, 0, 0, 1, 64'h1234, 2'd2, 0);
    txn(3, 0, 1, 64'h0, 64'h5000_0040, 0, 1, 0, 64'h5678, 2'd3, 0);
    txn(4, 1, 1, 64'h9000_0000, 64'h6000_0000, 0, 1, 0, 64'h0, 2'd0, 0);
    txn(5, 0, 1, 64'h0, 64'h7000_0000, 1, 0, 0, 64'h0, 2'd0, 0);
    txn(6, 1, 0, 64'hA000_0000, 64'h0, 0, 2, 1, 64'h0, 2'd0, 0);
    txn(7, 0, 1, 64'h0, 64'hB000_0000, 0, 0, 1, 64'h9ABC, 2'd1, 0);

    // Leave the fairness counter part-way, then reset mid-walk.
    allow_drop = 1'b0;
    fcnt = 0;
    txn(4, 0, 1, 64'h0, 64'h10, 0, 0, 0, 64'h0, 2'd0, 0);  // D grant, ITLB idle: clears
    txn(0, 1, 1, 64'h1000, 64'h2000, 0, 0, 0, 64'hAA, 2'd0, 0);
    txn(0, 1, 1, 64'h1000, 64'h2000, 0, 0, 0, 64'hBB, 2'd0, 0);
    t_grant(1, 1, 64'h1000, 64'h2000, 1);
    WalkAck = 1;
    tick();
    WalkAck = 0;
    #1;
    chk("rst_pre_busy", Busy, 1);
    reset = 0;
    tick();
    reset = 1; ITLBMissF = 0; DTLBMissM = 0; WalkDone = 1; WalkPTE = rnd64();
    fcnt = 0;
    #1;
    chk_all_zero("rst_walk");
    tick();
    WalkDone = 0;
    #1;
    chk_all_zero("rst_stale");

    // Both misses held through eight walks: D,D,D,I,D,D,D,I
    for (int k = 0; k < 8; k++) begin
      txn(0, 1, 1, 64'hC000_0000 + 64'(k), 64'hD000_0000 + 64'(k), 0, 0, 0, rnd64(), 2'd0, 0);
      seq[k] = obs_i;
    end
    chk("fair_seq", seq, 8'b1000_1000);
    allow_drop = 1'b1;

    for (int n = 0; n < 60; n++) begin
      scen = $urandom_range(0, 7);
      im = 1'($urandom);
      dm = 1'($urandom);
      if (!im && !dm) dm = 1;
      txn(scen, im, dm, rnd64(), rnd64(), 1'($urandom), $urandom_range(0, 2),
          $urandom_range(0, 2), rnd64(), 2'($urandom), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
